led_pwm_fader: RTL and testbench

Breathing-LED driver that sits directly downstream of the board's HFOSC clock divider. The divider's one-cycle tick strobe sets the fade rate. The block ramps a brightness level up and down through a four-phase state machine. It drives the LED pin with a registered, glitch-free PWM waveform, replacing the plain 1 Hz toggle with a smooth fade at the same pin.

---
 rtl/led_pwm_fader.sv | 117 +++++++++++
 tb/tb_led_pwm_fader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - breathing-LED fader: four-phase ramp/hold FSM driving a glitch-free registered PWM.
// Optional build macro LED_FADE_GAMMA_EN selects a square-law duty curve instead of linear.
module led_pwm_fader #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                enable,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [1:0]          phase
);

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HI   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LO   = 2'd3
  } phase_t;

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP_N  = PWM_BITS'(STEP);
  // A hold length of zero behaves as a single tick.
  localparam logic [16:0] HOLD_W = (HOLD_TICKS == 0) ? 17'd1 : 17'(HOLD_TICKS);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;
  logic [PWM_BITS-1:0] r_level;
  phase_t              r_phase;
  logic [15:0]         r_hold;

  logic [PWM_BITS:0]   w_sum;
  logic [16:0]         w_hold_inc;
  logic                w_hold_done;
  logic [PWM_BITS-1:0] w_duty_next;

  assign w_sum       = {1'b0, r_level} + {1'b0, STEP_N};
  assign w_hold_inc  = {1'b0, r_hold} + 17'd1;
  assign w_hold_done = (w_hold_inc >= HOLD_W);

`ifdef LED_FADE_GAMMA_EN
  logic [PWM_BITS-1:0] w_sq_lo_unused;
  assign {w_duty_next, w_sq_lo_unused} = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
`else
  assign w_duty_next = r_level;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_led     <= 1'b0;
      r_level   <= '0;
      r_phase   <= RAMP_UP;
      r_hold    <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      // Duty only changes at the wrap so every period is whole.
      if (r_pwm_cnt == LVL_MAX) begin
        r_duty <= w_duty_next;
      end
      r_led <= enable && (r_pwm_cnt < r_duty);

      if (!enable) begin
        r_level <= '0;
        r_phase <= RAMP_UP;
        r_hold  <= '0;
      end else if (tick) begin
        case (r_phase)
          RAMP_UP: begin
            if (w_sum >= {1'b0, LVL_MAX}) begin
              r_level <= LVL_MAX;
              r_hold  <= '0;
              r_phase <= HOLD_HI;
            end else begin
              r_level <= w_sum[PWM_BITS-1:0];
            end
          end
          HOLD_HI: begin
            if (w_hold_done) begin
              r_hold  <= '0;
              r_phase <= RAMP_DOWN;
            end else begin
              r_hold <= w_hold_inc[15:0];
            end
          end
          RAMP_DOWN: begin
            if (STEP_N >= r_level) begin
              r_level <= '0;
              r_hold  <= '0;
              r_phase <= HOLD_LO;
            end else begin
              r_level <= r_level - STEP_N;
            end
          end
          HOLD_LO: begin
            if (w_hold_done) begin
              r_hold  <= '0;
              r_phase <= RAMP_UP;
            end else begin
              r_hold <= w_hold_inc[15:0];
            end
          end
        endcase
      end
    end
  end

  assign led   = r_led;
  assign level = r_level;
  assign phase = r_phase;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - directed bench for led_pwm_fader (linear build, or gamma when LED_FADE_GAMMA_EN is defined).
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst, tick, enable, led;
  logic [7:0] level;
  logic [1:0] phase;
  logic       s_tick, s_en, s_led;
  logic [7:0] s_level;
  logic [1:0] s_phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_pwm_fader u_dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable),
    .led(led), .level(level), .phase(phase)
  );

  led_pwm_fader #(.PWM_BITS(8), .STEP(100), .HOLD_TICKS(2)) u_s100 (
    .clk(clk), .rst(rst), .tick(s_tick), .enable(s_en),
    .led(s_led), .level(s_level), .phase(s_phase)
  );

  typedef struct {
    logic t;
    logic e;
    int   lvl;
    int   ph;
  } s100_vec_t;

  typedef struct {
    int lvl;
    int hi_lin;
    int hi_gam;
  } duty_vec_t;

  s100_vec_t s100_tab[14];
  duty_vec_t duty_tab[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic set_level(input int l);
    enable = 1'b0;
    step();
    enable = 1'b1;
    tick   = 1'b1;
    repeat (l) step();
    tick = 1'b0;
    step();
    check($sformatf("set_level_%0d", l), level, l);
  endtask

  // Aligns to a PWM wrap, then counts led highs over one full period.
  task automatic measure_window(input int tick_at, output int highs);
    int guard;
    guard = 0;
    highs = 0;
    while (u_dut.r_pwm_cnt != 8'hFF && guard < 300) begin
      step();
      guard++;
    end
    check("pwm_align", guard < 300, 1);
    step();
    for (int j = 0; j < 256; j++) begin
      if (j == tick_at) tick = 1'b1;
      step();
      tick = 1'b0;
      if (led) highs++;
    end
  endtask

  function automatic int exp_hi(input duty_vec_t v);
`ifdef LED_FADE_GAMMA_EN
    return v.hi_gam;
`else
    return v.hi_lin;
`endif
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int guard;
    duty_vec_t v64, v65;

    s100_tab[0]  = '{1'b1, 1'b1, 100, 0};
    s100_tab[1]  = '{1'b1, 1'b1, 200, 0};
    s100_tab[2]  = '{1'b0, 1'b1, 200, 0};
    s100_tab[3]  = '{1'b1, 1'b1, 255, 1};
    s100_tab[4]  = '{1'b1, 1'b1, 255, 1};
    s100_tab[5]  = '{1'b1, 1'b1, 255, 2};
    s100_tab[6]  = '{1'b1, 1'b1, 155, 2};
    s100_tab[7]  = '{1'b1, 1'b1,  55, 2};
    s100_tab[8]  = '{1'b1, 1'b1,   0, 3};
    s100_tab[9]  = '{1'b1, 1'b1,   0, 3};
    s100_tab[10] = '{1'b1, 1'b1,   0, 0};
    s100_tab[11] = '{1'b1, 1'b1, 100, 0};
    s100_tab[12] = '{1'b1, 1'b0,   0, 0};
    s100_tab[13] = '{1'b1, 1'b1, 100, 0};

    duty_tab[0] = '{0,     0,   0};
    duty_tab[1] = '{15,   15,   0};
    duty_tab[2] = '{64,   64,  16};
    duty_tab[3] = '{128, 128,  64};
    duty_tab[4] = '{255, 255, 254};
    v64 = '{64, 64, 16};
    v65 = '{65, 65, 16};

    rst = 1'b1; tick = 1'b1; enable = 1'b1; s_tick = 1'b0; s_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_led_%0d", i), led, 0);
      check($sformatf("rst_level_%0d", i), level, 0);
      check($sformatf("rst_phase_%0d", i), phase, 0);
    end
    rst = 1'b0; tick = 1'b0;
    step();
    check("post_rst_led", led, 0);
    check("post_rst_level", level, 0);
    check("post_rst_phase", phase, 0);

    for (int i = 0; i < 14; i++) begin
      s_tick = s100_tab[i].t;
      s_en   = s100_tab[i].e;
      step();
      check($sformatf("s100_level_%0d", i), s_level, s100_tab[i].lvl);
      check($sformatf("s100_phase_%0d", i), s_phase, s100_tab[i].ph);
    end
    s_tick = 1'b0;

    for (int i = 1; i <= 255; i++) begin
      do_tick();
      check($sformatf("ramp_up_level_%0d", i), level, i);
      if (i == 254) check("ramp_up_phase_254", phase, 0);
    end
    check("hold_hi_entry", phase, 1);
    for (int i = 1; i <= 16; i++) begin
      do_tick();
      if (i == 15) check("hold_hi_15", phase, 1);
    end
    check("ramp_down_entry", phase, 2);
    check("ramp_down_start_level", level, 255);
    for (int i = 1; i <= 255; i++) begin
      do_tick();
      check($sformatf("ramp_down_level_%0d", i), level, 255 - i);
    end
    check("hold_lo_entry", phase, 3);
    for (int i = 1; i <= 16; i++) begin
      do_tick();
      if (i == 15) check("hold_lo_15", phase, 3);
    end
    check("ramp_up_again", phase, 0);

    for (int i = 0; i < 5; i++) begin
      set_level(duty_tab[i].lvl);
      measure_window(-1, h);
      check($sformatf("duty_highs_lvl%0d", duty_tab[i].lvl), h, exp_hi(duty_tab[i]));
    end

    set_level(64);
    measure_window(100, h);
    check("mid_tick_window", h, exp_hi(v64));
    check("mid_tick_level", level, 65);
    measure_window(-1, h);
    check("after_tick_window", h, exp_hi(v65));

    set_level(120);
    repeat (256) step();
    guard = 0;
    while (u_dut.r_pwm_cnt != 8'd10 && guard < 300) begin
      step();
      guard++;
    end
    check("drop_align", guard < 300, 1);
    check("pre_drop_led", led, 1);
    enable = 1'b0; tick = 1'b1;
    step();
    check("drop_led", led, 0);
    check("drop_level", level, 0);
    check("drop_phase", phase, 0);
    repeat (3) step();
    check("drop_hold_level", level, 0);
    check("drop_hold_led", led, 0);
    enable = 1'b1;
    step();
    tick = 1'b0;
    check("reenable_level", level, 1);
    check("reenable_phase", phase, 0);

    repeat (4) do_tick();
    check("pre_rst_level", level, 5);
    rst = 1'b1;
    step();
    check("mid_rst_level", level, 0);
    check("mid_rst_phase", phase, 0);
    check("mid_rst_led", led, 0);
    rst = 1'b0;
    do_tick();
    check("after_rst_level", level, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
